// File: rtl/wb_cmd_initiator.sv
// Wishbone initiator: accepts one command at a time, runs it on the bus with a
// bounded wait for ACK, and returns read data or a timeout error.
`timescale 1ns/1ps
module wb_cmd_initiator #(
    parameter int                     ADDRWIDTH      = 17,
    parameter int                     DATAWIDTH      = 32,
    parameter int                     TIMEOUT_CYCLES = 255,
    parameter int                     TIMEOUT_WIDTH  = 8,
    parameter logic [DATAWIDTH-1:0]   ERR_READ_VALUE = 32'hDEAD_0ACC
) (
    input  logic                      WBs_CLK_i,
    input  logic                      WBs_RSTn_i,
    input  logic                      cmd_valid_i,
    output logic                      cmd_ready_o,
    input  logic                      cmd_we_i,
    input  logic [ADDRWIDTH-1:0]      cmd_adr_i,
    input  logic [DATAWIDTH/8-1:0]    cmd_be_i,
    input  logic [DATAWIDTH-1:0]      cmd_wdat_i,
    output logic                      rsp_valid_o,
    input  logic                      rsp_ready_i,
    output logic [DATAWIDTH-1:0]      rsp_rdat_o,
    output logic                      rsp_err_o,
    output logic [ADDRWIDTH-1:0]      WBm_ADR_o,
    output logic                      WBm_CYC_o,
    output logic                      WBm_STB_o,
    output logic                      WBm_WE_o,
    output logic                      WBm_RD_o,
    output logic [DATAWIDTH/8-1:0]    WBm_BYTE_STB_o,
    output logic [DATAWIDTH-1:0]      WBm_WR_DAT_o,
    input  logic [DATAWIDTH-1:0]      WBm_RD_DAT_i,
    input  logic                      WBm_ACK_i,
    output logic                      busy_o,
    output logic [7:0]                err_cnt_o
);

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    state_t                   state_q, state_d;
    logic                     we_q;
    logic [ADDRWIDTH-1:0]     adr_q;
    logic [DATAWIDTH/8-1:0]   be_q;
    logic [DATAWIDTH-1:0]     wdat_q;
    logic [DATAWIDTH-1:0]     rdat_q;
    logic                     err_q;
    logic [TIMEOUT_WIDTH-1:0] cnt_q;
    logic [7:0]               err_cnt_q;
    logic                     ack_hit;
    logic                     timeout;

    // ACK takes priority over a timeout landing on the same cycle.
    assign ack_hit = (state_q == BUS) && WBm_ACK_i;
    assign timeout = (state_q == BUS) && !WBm_ACK_i &&
                     (cnt_q == TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1));

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge WBs_CLK_i or negedge WBs_RSTn_i) begin
        if (!WBs_RSTn_i) state_q <= IDLE;
        else             state_q <= state_d;
    end

    // NOTE: default assignment first so no path leaves state_d unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (cmd_valid_i)         state_d = BUS;
            BUS:     if (ack_hit || timeout)  state_d = RESP;
            RESP:    if (rsp_ready_i)         state_d = IDLE;
            default:                          state_d = IDLE;
        endcase
    end

    // Bus-side registers are zeroed on leaving BUS so the bus idles at 0.
    always_ff @(posedge WBs_CLK_i or negedge WBs_RSTn_i) begin
        if (!WBs_RSTn_i) begin
            we_q      <= 1'b0;
            adr_q     <= '0;
            be_q      <= '0;
            wdat_q    <= '0;
            rdat_q    <= '0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
            err_cnt_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (cmd_valid_i) begin
                        we_q   <= cmd_we_i;
                        adr_q  <= cmd_adr_i;
                        be_q   <= cmd_be_i;
                        wdat_q <= cmd_wdat_i;
                        cnt_q  <= '0;
                    end
                end
                BUS: begin
                    if (ack_hit || timeout) begin
                        we_q   <= 1'b0;
                        adr_q  <= '0;
                        be_q   <= '0;
                        wdat_q <= '0;
                    end
                    if (ack_hit) begin
                        rdat_q <= we_q ? '0 : WBm_RD_DAT_i;
                        err_q  <= 1'b0;
                    end else if (timeout) begin
                        rdat_q <= ERR_READ_VALUE;
                        err_q  <= 1'b1;
                        if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        rdat_q <= '0;
                        err_q  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign cmd_ready_o    = (state_q == IDLE);
    assign busy_o         = (state_q != IDLE);
    assign rsp_valid_o    = (state_q == RESP);
    assign rsp_rdat_o     = rdat_q;
    assign rsp_err_o      = err_q;
    assign WBm_CYC_o      = (state_q == BUS);
    assign WBm_STB_o      = (state_q == BUS);
    assign WBm_WE_o       = we_q;
    assign WBm_RD_o       = (state_q == BUS) && !we_q;
    assign WBm_ADR_o      = adr_q;
    assign WBm_BYTE_STB_o = be_q;
    assign WBm_WR_DAT_o   = wdat_q;
    assign err_cnt_o      = err_cnt_q;

endmodule

// File: tb/tb_wb_cmd_initiator.sv
// Bench for wb_cmd_initiator: directed vector table, hand-written corner
// sequences, and randomized transactions scored against a transaction model.
`timescale 1ns/1ps
module tb_wb_cmd_initiator;

    localparam int T = 7;

    logic        WBs_CLK_i = 1'b0;
    logic        WBs_RSTn_i = 1'b0;
    logic        cmd_valid_i = 1'b0;
    logic        cmd_ready_o;
    logic        cmd_we_i = 1'b0;
    logic [16:0] cmd_adr_i = '0;
    logic [3:0]  cmd_be_i = '0;
    logic [31:0] cmd_wdat_i = '0;
    logic        rsp_valid_o;
    logic        rsp_ready_i = 1'b0;
    logic [31:0] rsp_rdat_o;
    logic        rsp_err_o;
    logic [16:0] WBm_ADR_o;
    logic        WBm_CYC_o;
    logic        WBm_STB_o;
    logic        WBm_WE_o;
    logic        WBm_RD_o;
    logic [3:0]  WBm_BYTE_STB_o;
    logic [31:0] WBm_WR_DAT_o;
    logic [31:0] WBm_RD_DAT_i = '0;
    logic        WBm_ACK_i = 1'b0;
    logic        busy_o;
    logic [7:0]  err_cnt_o;

    wb_cmd_initiator #(.TIMEOUT_CYCLES(T)) dut (
        .WBs_CLK_i(WBs_CLK_i), .WBs_RSTn_i(WBs_RSTn_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_we_i(cmd_we_i), .cmd_adr_i(cmd_adr_i), .cmd_be_i(cmd_be_i),
        .cmd_wdat_i(cmd_wdat_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_rdat_o(rsp_rdat_o), .rsp_err_o(rsp_err_o),
        .WBm_ADR_o(WBm_ADR_o), .WBm_CYC_o(WBm_CYC_o), .WBm_STB_o(WBm_STB_o),
        .WBm_WE_o(WBm_WE_o), .WBm_RD_o(WBm_RD_o),
        .WBm_BYTE_STB_o(WBm_BYTE_STB_o), .WBm_WR_DAT_o(WBm_WR_DAT_o),
        .WBm_RD_DAT_i(WBm_RD_DAT_i), .WBm_ACK_i(WBm_ACK_i),
        .busy_o(busy_o), .err_cnt_o(err_cnt_o)
    );

    always #5 WBs_CLK_i = ~WBs_CLK_i;

    int checks = 0;
    int errors = 0;
    int m_err_cnt = 0;

    typedef struct {
        logic        we;
        logic [16:0] adr;
        logic [3:0]  be;
        logic [31:0] wdat;
        int          ack_at;   // CYC cycle (1-based) on which ACK is given; 0 = never
        logic [31:0] rd;
        int          bp;       // cycles rsp_ready_i is held low
        int          exp_len;
        logic [31:0] exp_rdat;
        logic        exp_err;
        int          exp_cnt;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Transaction-level model: outcome depends only on whether ACK arrives
    // within the allowed window.
    task automatic model(input logic we, input int ack_at, input logic [31:0] rd,
                         output int len, output logic [31:0] rdat, output logic err);
        if (ack_at >= 1 && ack_at <= T) begin
            len  = ack_at;
            rdat = we ? 32'h0 : rd;
            err  = 1'b0;
        end else begin
            len  = T;
            rdat = 32'hDEAD_0ACC;
            err  = 1'b1;
            if (m_err_cnt < 255) m_err_cnt++;
        end
    endtask

    task automatic run_txn(input logic we, input logic [16:0] adr, input logic [3:0] be,
                           input logic [31:0] wdat, input int ack_at, input logic [31:0] rd,
                           input int bp, output int len, output logic [31:0] rdat,
                           output logic err);
        int n;
        @(negedge WBs_CLK_i);
        check("cmd_ready_idle", 32'(cmd_ready_o), 32'd1);
        cmd_valid_i = 1'b1;
        cmd_we_i    = we;
        cmd_adr_i   = adr;
        cmd_be_i    = be;
        cmd_wdat_i  = wdat;
        rsp_ready_i = (bp == 0);
        @(negedge WBs_CLK_i);
        cmd_valid_i = 1'b0;
        cmd_wdat_i  = $urandom;
        n = 0;
        while (WBm_CYC_o && n < 300) begin
            n++;
            check("bus_stb", 32'(WBm_STB_o), 32'd1);
            check("bus_adr", 32'(WBm_ADR_o), 32'(adr));
            check("bus_we", 32'(WBm_WE_o), 32'(we));
            check("bus_rd", 32'(WBm_RD_o), 32'(!we));
            check("bus_be", 32'(WBm_BYTE_STB_o), 32'(be));
            check("bus_wdat", WBm_WR_DAT_o, wdat);
            check("bus_cmd_ready", 32'(cmd_ready_o), 32'd0);
            if (n == ack_at) begin
                WBm_ACK_i    = 1'b1;
                WBm_RD_DAT_i = rd;
            end
            @(negedge WBs_CLK_i);
            WBm_ACK_i    = 1'b0;
            WBm_RD_DAT_i = $urandom;
        end
        if (n >= 300) check("bus_timeout_bound", 32'(n), 32'd0);
        len = n;
        check("rsp_valid", 32'(rsp_valid_o), 32'd1);
        rdat = rsp_rdat_o;
        err  = rsp_err_o;
        for (int i = 0; i < bp; i++) begin
            check("bp_valid", 32'(rsp_valid_o), 32'd1);
            check("bp_rdat", rsp_rdat_o, rdat);
            check("bp_err", 32'(rsp_err_o), 32'(err));
            check("bp_cmd_ready", 32'(cmd_ready_o), 32'd0);
            check("bp_cyc", 32'(WBm_CYC_o), 32'd0);
            check("bp_adr", 32'(WBm_ADR_o), 32'd0);
            WBm_ACK_i    = i[0];
            WBm_RD_DAT_i = $urandom;
            @(negedge WBs_CLK_i);
        end
        WBm_ACK_i   = 1'b0;
        rsp_ready_i = 1'b1;
        @(negedge WBs_CLK_i);
        check("post_rsp_valid", 32'(rsp_valid_o), 32'd0);
        check("post_cmd_ready", 32'(cmd_ready_o), 32'd1);
        rsp_ready_i = 1'b0;
    endtask

    initial begin
        vec_t        vecs[6];
        int          len, m_len;
        logic [31:0] rdat, m_rdat;
        logic        err, m_err;

        vecs[0] = '{1'b1, 17'h04004, 4'hF, 32'hA5A5_0001, 2, 32'h0, 0, 2, 32'h0, 1'b0, 0};
        vecs[1] = '{1'b0, 17'h05000, 4'hF, 32'h0, 1, 32'h1234_5678, 0, 1, 32'h1234_5678, 1'b0, 0};
        vecs[2] = '{1'b0, 17'h04010, 4'h3, 32'h0, 0, 32'h0, 0, 7, 32'hDEAD_0ACC, 1'b1, 1};
        vecs[3] = '{1'b0, 17'h04020, 4'hF, 32'h0, 7, 32'hCAFE_F00D, 0, 7, 32'hCAFE_F00D, 1'b0, 1};
        vecs[4] = '{1'b1, 17'h05004, 4'h8, 32'h1111_2222, 0, 32'h0, 1, 7, 32'hDEAD_0ACC, 1'b1, 2};
        vecs[5] = '{1'b0, 17'h04008, 4'hC, 32'h0, 3, 32'h0BAD_BEEF, 5, 3, 32'h0BAD_BEEF, 1'b0, 2};

        // Reset values
        #2;
        check("rst_cmd_ready", 32'(cmd_ready_o), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        check("rst_rsp_rdat", rsp_rdat_o, 32'd0);
        check("rst_rsp_err", 32'(rsp_err_o), 32'd0);
        check("rst_bus", {WBm_CYC_o, WBm_STB_o, WBm_WE_o, WBm_RD_o, WBm_BYTE_STB_o, 15'd0, WBm_ADR_o[8:0]}, 32'd0);
        check("rst_bus_adr", 32'(WBm_ADR_o), 32'd0);
        check("rst_bus_wdat", WBm_WR_DAT_o, 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_err_cnt", 32'(err_cnt_o), 32'd0);
        @(negedge WBs_CLK_i);
        WBs_RSTn_i = 1'b1;

        // Directed vector table
        for (int i = 0; i < 6; i++) begin
            run_txn(vecs[i].we, vecs[i].adr, vecs[i].be, vecs[i].wdat, vecs[i].ack_at,
                    vecs[i].rd, vecs[i].bp, len, rdat, err);
            model(vecs[i].we, vecs[i].ack_at, vecs[i].rd, m_len, m_rdat, m_err);
            check($sformatf("vec%0d_len", i), 32'(len), 32'(vecs[i].exp_len));
            check($sformatf("vec%0d_rdat", i), rdat, vecs[i].exp_rdat);
            check($sformatf("vec%0d_err", i), 32'(err), 32'(vecs[i].exp_err));
            check($sformatf("vec%0d_err_cnt", i), 32'(err_cnt_o), 32'(vecs[i].exp_cnt));
        end

        // Minimum turnaround: back-to-back reads with immediate ACK, ready held high
        @(negedge WBs_CLK_i);
        rsp_ready_i = 1'b1;
        cmd_valid_i = 1'b1;
        cmd_we_i = 1'b0;
        cmd_adr_i = 17'h05000;
        cmd_be_i = 4'hF;
        WBm_ACK_i = 1'b1;
        WBm_RD_DAT_i = 32'h1234_5678;
        for (int c = 0; c < 6; c++) begin
            @(negedge WBs_CLK_i);
            check("turn_cyc", 32'(WBm_CYC_o), 32'((c % 3) == 0));
            check("turn_rsp_valid", 32'(rsp_valid_o), 32'((c % 3) == 1));
            check("turn_cmd_ready", 32'(cmd_ready_o), 32'((c % 3) == 2));
            if ((c % 3) == 1) check("turn_rdat", rsp_rdat_o, 32'h1234_5678);
        end
        cmd_valid_i = 1'b0;
        WBm_ACK_i = 1'b0;
        rsp_ready_i = 1'b0;

        // Stray ACK while idle must not start anything
        @(negedge WBs_CLK_i);
        WBm_ACK_i = 1'b1;
        @(negedge WBs_CLK_i);
        WBm_ACK_i = 1'b0;
        check("stray_idle_cyc", 32'(WBm_CYC_o), 32'd0);
        check("stray_idle_busy", 32'(busy_o), 32'd0);
        check("stray_idle_rsp", 32'(rsp_valid_o), 32'd0);

        // Randomized transactions against the model
        for (int i = 0; i < 40; i++) begin
            logic        we;
            logic [31:0] wdat, rd;
            int          ack_at, bp;
            we     = 1'($urandom);
            wdat   = $urandom;
            rd     = $urandom;
            ack_at = $urandom_range(0, 9);
            bp     = $urandom_range(0, 3);
            run_txn(we, 17'($urandom), 4'($urandom), wdat, ack_at, rd, bp, len, rdat, err);
            model(we, ack_at, rd, m_len, m_rdat, m_err);
            check("rnd_len", 32'(len), 32'(m_len));
            check("rnd_rdat", rdat, m_rdat);
            check("rnd_err", 32'(err), 32'(m_err));
            check("rnd_err_cnt", 32'(err_cnt_o), 32'(m_err_cnt));
        end

        // Reset asserted on the 3rd CYC cycle
        @(negedge WBs_CLK_i);
        cmd_valid_i = 1'b1;
        cmd_we_i = 1'b0;
        cmd_adr_i = 17'h04000;
        @(negedge WBs_CLK_i);
        cmd_valid_i = 1'b0;
        @(negedge WBs_CLK_i);
        @(negedge WBs_CLK_i);
        check("rstmid_cyc_before", 32'(WBm_CYC_o), 32'd1);
        #2 WBs_RSTn_i = 1'b0;
        #1;
        check("rstmid_cyc", 32'(WBm_CYC_o), 32'd0);
        check("rstmid_stb", 32'(WBm_STB_o), 32'd0);
        check("rstmid_busy", 32'(busy_o), 32'd0);
        check("rstmid_err_cnt", 32'(err_cnt_o), 32'd0);
        m_err_cnt = 0;
        #7 WBs_RSTn_i = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge WBs_CLK_i);
            check("rstmid_no_rsp", 32'(rsp_valid_o), 32'd0);
            check("rstmid_idle", 32'(WBm_CYC_o), 32'd0);
        end
        run_txn(1'b1, 17'h04004, 4'hF, 32'h5555_AAAA, 1, 32'h0, 0, len, rdat, err);
        check("rstmid_next_len", 32'(len), 32'd1);
        check("rstmid_next_err", 32'(err), 32'd0);

        // Error counter saturation
        for (int i = 0; i < 300; i++) begin
            run_txn(1'b0, 17'h04000, 4'hF, 32'h0, 0, 32'h0, 0, len, rdat, err);
            model(1'b0, 0, 32'h0, m_len, m_rdat, m_err);
        end
        check("sat_err_cnt", 32'(err_cnt_o), 32'd255);
        check("sat_model_cnt", 32'(err_cnt_o), 32'(m_err_cnt));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
